bitslip_align: RTL and testbench

//  Multi-lane ADC frame aligner; parametrised successor of the single-lane bitslip pulser.
//  Per lane: compares the deserialised word with the FRAME pattern, issues spaced BITSLIP pulses

---
 rtl/bitslip_align_pkg.sv | 22 ++
 rtl/bitslip_align_lane.sv | 128 ++++++++++++
 rtl/bitslip_align.sv | 55 +++++
 tb/tb_bitslip_align.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitslip_align_pkg.sv
// bitslip_align shared definitions: lane FSM state encoding, counter width, saturating increment.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package bitslip_align_pkg;

  // Lane FSM state encoding (2 bits)
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOCK = 2'd2,
    ST_FAIL = 2'd3
  } lane_state_t;

  // Width of the match / miss / slip counters; thresholds are limited to 1..255
  localparam int CNTW = 8;

  // Counters stick at all-ones instead of wrapping back to zero
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bitslip_align_lane.sv
// One lane of the frame aligner: compare word with FRAME, pulse BS, track lock/unlock/fail.
// Latency: all outputs registered, 1 CLK after the sampled DATA word.
// Backpressure: none; BSENB gates BS generation, RESTART clears the lane synchronously.
module bitslip_align_lane
  import bitslip_align_pkg::*;
#(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] FRAME     = 6'b111000,
  parameter int               HOLDOFF   = 15,
  parameter int               LOCKCNT   = 8,
  parameter int               UNLOCKCNT = 4,
  parameter int               MAXSLIP   = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data,
  input  logic             bsenb,
  input  logic             restart,
  output logic             bs,
  output logic             locked,
  output logic             fail
);

  // HOLDOFF must be at least 1; the hold counter counts HOLDOFF down to 1
  localparam int HOLDW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  localparam logic [CNTW-1:0]  LOCK_N   = CNTW'(LOCKCNT);
  localparam logic [CNTW-1:0]  UNLOCK_N = CNTW'(UNLOCKCNT);
  localparam logic [CNTW-1:0]  SLIP_N   = CNTW'(MAXSLIP);
  localparam logic [HOLDW-1:0] HOLD_N   = HOLDW'(HOLDOFF);
  localparam logic [HOLDW-1:0] HOLD_ONE = HOLDW'(1);

  lane_state_t      st;
  logic [CNTW-1:0]  match_cnt;
  logic [CNTW-1:0]  miss_cnt;
  logic [CNTW-1:0]  slip_cnt;
  logic [HOLDW-1:0] hold_cnt;

  logic            hit;
  logic [CNTW-1:0] match_nxt;
  logic [CNTW-1:0] miss_nxt;
  logic [CNTW-1:0] slip_nxt;

  assign hit       = (data == FRAME);
  assign match_nxt = sat_inc(match_cnt);
  assign miss_nxt  = sat_inc(miss_cnt);
  assign slip_nxt  = sat_inc(slip_cnt);

  // Lane FSM with registered BS/LOCKED/FAIL; RST beats RESTART beats normal operation
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st        <= ST_HUNT;
      match_cnt <= '0;
      miss_cnt  <= '0;
      slip_cnt  <= '0;
      hold_cnt  <= '0;
      bs        <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else if (restart) begin
      st        <= ST_HUNT;
      match_cnt <= '0;
      miss_cnt  <= '0;
      slip_cnt  <= '0;
      hold_cnt  <= '0;
      bs        <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      bs <= 1'b0;
      case (st)
        ST_HUNT: begin
          if (hit) begin
            match_cnt <= match_nxt;
            if (match_nxt >= LOCK_N) begin
              st       <= ST_LOCK;
              locked   <= 1'b1;
              miss_cnt <= '0;
            end
          end else begin
            match_cnt <= '0;
            if (bsenb) begin
              // The pulse that exhausts the slip budget is still issued
              bs       <= 1'b1;
              slip_cnt <= slip_nxt;
              if (slip_nxt >= SLIP_N) begin
                st   <= ST_FAIL;
                fail <= 1'b1;
              end else begin
                st       <= ST_HOLD;
                hold_cnt <= HOLD_N;
              end
            end
          end
        end
        ST_HOLD: begin
          // DATA is ignored while the ISERDES settles after a slip
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HOLD_ONE) begin
            st <= ST_HUNT;
          end
        end
        ST_LOCK: begin
          if (hit) begin
            miss_cnt <= '0;
          end else begin
            miss_cnt <= miss_nxt;
            if (miss_nxt >= UNLOCK_N) begin
              st        <= ST_HUNT;
              locked    <= 1'b0;
              match_cnt <= '0;
              slip_cnt  <= '0;
              miss_cnt  <= '0;
            end
          end
        end
        ST_FAIL: begin
          fail   <= 1'b1;
          locked <= 1'b0;
        end
        default: begin
          st <= ST_HUNT;
        end
      endcase
    end
  end

endmodule

// File: rtl/bitslip_align.sv
// Multi-lane ADC frame aligner: NLANES independent bitslip lanes plus a registered all-locked flag.
// Latency: BS/LOCKED/FAIL 1 CLK after the sampled word; ALLLOCK 1 CLK after LOCKED.
// Backpressure: none; BSENB gates bitslip generation on every lane, RESTART re-hunts all lanes.
module bitslip_align
  import bitslip_align_pkg::*;
#(
  parameter int               NLANES    = 2,
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] FRAME     = 6'b111000,
  parameter int               HOLDOFF   = 15,
  parameter int               LOCKCNT   = 8,
  parameter int               UNLOCKCNT = 4,
  parameter int               MAXSLIP   = 12
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NLANES*WIDTH-1:0] DATA,
  input  logic                    BSENB,
  input  logic                    RESTART,
  output logic [NLANES-1:0]       BS,
  output logic [NLANES-1:0]       LOCKED,
  output logic [NLANES-1:0]       FAIL,
  output logic                    ALLLOCK
);

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    bitslip_align_lane #(
      .WIDTH     (WIDTH),
      .FRAME     (FRAME),
      .HOLDOFF   (HOLDOFF),
      .LOCKCNT   (LOCKCNT),
      .UNLOCKCNT (UNLOCKCNT),
      .MAXSLIP   (MAXSLIP)
    ) u_lane (
      .CLK     (CLK),
      .RST     (RST),
      .data    (DATA[i*WIDTH +: WIDTH]),
      .bsenb   (BSENB),
      .restart (RESTART),
      .bs      (BS[i]),
      .locked  (LOCKED[i]),
      .fail    (FAIL[i])
    );
  end

  // Registered AND of all lane lock flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ALLLOCK <= 1'b0;
    end else begin
      ALLLOCK <= &LOCKED;
    end
  end

endmodule

// File: tb/tb_bitslip_align.sv
// Bench for bitslip_align: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model outputs represent the registered values after each CLK edge.
// Backpressure: n/a.
module tb_bitslip_align;

  localparam int NL = 2;
  localparam int W  = 6;
  localparam logic [W-1:0] FRAME = 6'b111000;
  localparam int HOLDOFF = 15;
  localparam int LOCKCNT = 8;
  localparam int UNLOCKCNT = 4;
  localparam int MAXSLIP = 12;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [NL*W-1:0] DATA = '0;
  logic            BSENB = 1'b0;
  logic            RESTART = 1'b0;
  logic [NL-1:0]   BS;
  logic [NL-1:0]   LOCKED;
  logic [NL-1:0]   FAIL;
  logic            ALLLOCK;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  bitslip_align dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .BSENB(BSENB), .RESTART(RESTART),
    .BS(BS), .LOCKED(LOCKED), .FAIL(FAIL), .ALLLOCK(ALLLOCK)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // Per lane: a holdoff countdown, run lengths of matches/misses, slip tally, and flags.
  int m_match[NL], m_miss[NL], m_slip[NL], m_hold[NL];
  bit m_lock[NL], m_fail[NL], m_bs[NL];
  bit m_all;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_all = 1'b0;
      for (int l = 0; l < NL; l++) begin
        m_match[l] = 0; m_miss[l] = 0; m_slip[l] = 0; m_hold[l] = 0;
        m_lock[l] = 1'b0; m_fail[l] = 1'b0; m_bs[l] = 1'b0;
      end
    end else begin
      m_all = m_lock[0] & m_lock[1];
      for (int l = 0; l < NL; l++) begin
        logic [W-1:0] w;
        w = DATA[l*W +: W];
        m_bs[l] = 1'b0;
        if (RESTART) begin
          m_match[l] = 0; m_miss[l] = 0; m_slip[l] = 0; m_hold[l] = 0;
          m_lock[l] = 1'b0; m_fail[l] = 1'b0;
        end else if (m_fail[l]) begin
          // parked until restart
        end else if (m_hold[l] > 0) begin
          m_hold[l] = m_hold[l] - 1;
        end else if (m_lock[l]) begin
          if (w == FRAME) m_miss[l] = 0;
          else begin
            m_miss[l] = m_miss[l] + 1;
            if (m_miss[l] >= UNLOCKCNT) begin
              m_lock[l] = 1'b0; m_match[l] = 0; m_slip[l] = 0; m_miss[l] = 0;
            end
          end
        end else if (w == FRAME) begin
          m_match[l] = m_match[l] + 1;
          if (m_match[l] >= LOCKCNT) begin
            m_lock[l] = 1'b1; m_miss[l] = 0;
          end
        end else begin
          m_match[l] = 0;
          if (BSENB) begin
            m_bs[l] = 1'b1;
            m_slip[l] = m_slip[l] + 1;
            if (m_slip[l] >= MAXSLIP) m_fail[l] = 1'b1;
            else m_hold[l] = HOLDOFF;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model, sampled on the falling edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check("bs",      32'(BS),      32'({m_bs[1], m_bs[0]}));
      check("locked",  32'(LOCKED),  32'({m_lock[1], m_lock[0]}));
      check("fail",    32'(FAIL),    32'({m_fail[1], m_fail[0]}));
      check("alllock", 32'(ALLLOCK), 32'(m_all));
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic set_lane(input int l, input logic [W-1:0] v);
    DATA[l*W +: W] = v;
  endtask

  function automatic logic [W-1:0] wrong_word();
    logic [W-1:0] v;
    v = W'($urandom);
    if (v == FRAME) v = ~FRAME;
    return v;
  endfunction

  initial begin
    int cyc;
    int pulses, last, gap_min, gap_max;
    bit bs_seen;
    int mode[NL];
    logic [W-1:0] cword[NL];

    // ---- reset and test 1: FRAME on both lanes ----
    #1 RST = 1'b1;
    set_lane(0, FRAME); set_lane(1, FRAME); BSENB = 1'b1;
    #2;
    chk_en = 1'b1;
    check("rst_bs", 32'(BS), 32'd0);
    check("rst_locked", 32'(LOCKED), 32'd0);
    check("rst_fail", 32'(FAIL), 32'd0);
    check("rst_alllock", 32'(ALLLOCK), 32'd0);
    step(); step();
    RST = 1'b0;
    cyc = 0; bs_seen = 1'b0;
    do begin
      step(); cyc++;
      if (BS != 0) bs_seen = 1'b1;
    end while (LOCKED != 2'b11 && cyc < 50);
    check("t1_lock_cycles", 32'(cyc), 32'd8);
    check("t1_alllock_lag", 32'(ALLLOCK), 32'd0);
    step();
    check("t1_alllock", 32'(ALLLOCK), 32'd1);
    check("t1_no_bs", 32'(bs_seen), 32'd0);

    // ---- test 4: lane1 tolerates 3 misses, drops on 4 ----
    set_lane(1, 6'b000111);
    step(); step(); step();
    set_lane(1, FRAME);
    step();
    check("t4_still_locked", 32'(LOCKED[1]), 32'd1);
    set_lane(1, 6'b000111);
    step(); step(); step(); step();
    check("t4_unlocked", 32'(LOCKED[1]), 32'd0);
    check("t4_no_bs_yet", 32'(BS[1]), 32'd0);
    step();
    check("t4_bs_next", 32'(BS[1]), 32'd1);

    // ---- test 2: lane0 stuck wrong, 12 pulses at 16 CLK spacing then FAIL ----
    RESTART = 1'b1; set_lane(1, FRAME); set_lane(0, 6'b110001);
    step();
    RESTART = 1'b0;
    pulses = 0; last = -1; gap_min = 1000; gap_max = 0;
    for (int c = 0; c < 260; c++) begin
      step();
      if (BS[0]) begin
        if (last >= 0) begin
          if (c - last < gap_min) gap_min = c - last;
          if (c - last > gap_max) gap_max = c - last;
        end
        last = c; pulses++;
      end
    end
    check("t2_pulses", 32'(pulses), 32'd12);
    check("t2_gap_min", 32'(gap_min), 32'd16);
    check("t2_gap_max", 32'(gap_max), 32'd16);
    check("t2_fail", 32'(FAIL[0]), 32'd1);

    // ---- test 5: BSENB low, wrong data -> no BS, no FAIL ----
    RESTART = 1'b1; BSENB = 1'b0;
    step();
    RESTART = 1'b0; bs_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (BS[0]) bs_seen = 1'b1;
    end
    check("t5_no_bs", 32'(bs_seen), 32'd0);
    check("t5_no_fail", 32'(FAIL[0]), 32'd0);
    // restart in HOLD
    BSENB = 1'b1;
    step(); step(); step();
    RESTART = 1'b1;
    step();
    RESTART = 1'b0;

    // ---- test 6: async reset mid-HOLD ----
    step(); step();
    #2 RST = 1'b1;
    #1;
    check("t6_bs", 32'(BS), 32'd0);
    check("t6_locked", 32'(LOCKED), 32'd0);
    check("t6_fail", 32'(FAIL), 32'd0);
    step();
    RST = 1'b0;
    set_lane(0, FRAME);
    step(); step();
    check("t6_no_bs", 32'(BS[0]), 32'd0);

    // ---- randomized traffic ----
    for (int l = 0; l < NL; l++) begin mode[l] = 0; cword[l] = wrong_word(); end
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 63) == 0) begin
          mode[l] = $urandom_range(0, 3);
          cword[l] = wrong_word();
        end
        case (mode[l])
          0: set_lane(l, FRAME);
          1: set_lane(l, ($urandom_range(0, 7) == 0) ? (FRAME ^ W'(1 << $urandom_range(0, W-1))) : FRAME);
          2: set_lane(l, W'($urandom));
          default: set_lane(l, cword[l]);
        endcase
      end
      BSENB = ($urandom_range(0, 9) != 0);
      RESTART = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 RST = 1'b1;
        #1 check("rnd_rst_outs", 32'({BS, LOCKED, FAIL}), 32'd0);
        step();
        RST = 1'b0;
      end
    end

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
